// File: rtl/slow_tick_ctrl.sv
// slow_tick_ctrl: run-time configurable slow-clock generator.
// Derives a glitch-free 50% SLOWCLK and a one-cycle TICK enable from CLK
// at 1, 2, 10 or 100 Hz. Rate changes use a REQ/ACK handshake and are only
// applied on a half-period boundary, so SLOWCLK never produces a short pulse.
module slow_tick_ctrl #(
    parameter int CLK_HZ = 100_000_000,  // must be a multiple of 200
    parameter int CNT_W  = 27            // must hold CLK_HZ/2 - 1
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       EN,
    input  logic [1:0] RATE_SEL,
    input  logic       CFG_REQ,
    output logic       CFG_ACK,
    output logic       SLOWCLK,
    output logic       TICK,
    output logic [7:0] TICK_CNT
);

    // Rate encodings: 00 = 1 Hz, 01 = 2 Hz, 10 = 10 Hz, 11 = 100 Hz.
    localparam logic [1:0] RATE_RESET = 2'b10;

    // Half-period terminal counts (HALF - 1) for each rate.
    localparam logic [CNT_W-1:0] HALF_M1_1HZ   = CNT_W'(CLK_HZ / 2 - 1);
    localparam logic [CNT_W-1:0] HALF_M1_2HZ   = CNT_W'(CLK_HZ / 4 - 1);
    localparam logic [CNT_W-1:0] HALF_M1_10HZ  = CNT_W'(CLK_HZ / 20 - 1);
    localparam logic [CNT_W-1:0] HALF_M1_100HZ = CNT_W'(CLK_HZ / 200 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_rate;       // active rate
    logic [1:0]       r_pend_sel;   // latched requested rate while pending
    logic [CNT_W-1:0] r_cnt;        // position within the current half period
    logic             r_slowclk;
    logic             r_tick;
    logic [7:0]       r_tick_cnt;
    logic             r_ack_due;    // rate applied, ACK goes out next cycle
    logic             r_ack;

    logic [CNT_W-1:0] w_half_m1;
    logic             w_boundary;
    logic             w_accept;

    // Terminal count for the active rate.
    always_comb begin
        w_half_m1 = HALF_M1_10HZ;
        case (r_rate)
            2'b00:   w_half_m1 = HALF_M1_1HZ;
            2'b01:   w_half_m1 = HALF_M1_2HZ;
            2'b10:   w_half_m1 = HALF_M1_10HZ;
            default: w_half_m1 = HALF_M1_100HZ;
        endcase
    end

    assign w_boundary = (r_cnt == w_half_m1);

    // A request is refused while its ACK is due or being shown, so a request
    // that is still held during the handshake is not taken a second time.
    assign w_accept = CFG_REQ && !r_ack_due && !r_ack;

    // Controller FSM, half-period counter and registered outputs.
    // NOTE: all state here uses <= so every branch reads the values from
    // before this edge; mixing in = would make results depend on statement order.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state    <= S_IDLE;
            r_rate     <= RATE_RESET;
            r_pend_sel <= RATE_RESET;
            r_cnt      <= '0;
            r_slowclk  <= 1'b0;
            r_tick     <= 1'b0;
            r_tick_cnt <= 8'd0;
            r_ack_due  <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are only raised by the
            // branches below, so each pulse lasts exactly one cycle.
            r_tick    <= 1'b0;
            r_ack     <= r_ack_due;
            r_ack_due <= 1'b0;

            if (!EN) begin
                // Disable wins over everything, including a coincident boundary.
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_slowclk <= 1'b0;
                if (r_state == S_PEND) begin
                    r_rate    <= r_pend_sel;
                    r_ack_due <= 1'b1;
                end else if (r_state == S_IDLE && w_accept) begin
                    r_rate    <= RATE_SEL;
                    r_ack_due <= 1'b1;
                end
            end else if (r_state == S_IDLE) begin
                r_state    <= S_RUN;
                r_cnt      <= '0;
                r_slowclk  <= 1'b0;
                r_tick_cnt <= 8'd0;
            end else begin
                if (w_boundary) begin
                    r_cnt     <= '0;
                    r_slowclk <= ~r_slowclk;
                    r_tick    <= ~r_slowclk;
                    if (r_state == S_PEND) begin
                        // New rate starts cleanly at a half-period boundary.
                        r_rate     <= r_pend_sel;
                        r_state    <= S_RUN;
                        r_ack_due  <= 1'b1;
                        r_tick_cnt <= {7'd0, ~r_slowclk};
                    end else if (!r_slowclk) begin
                        r_tick_cnt <= r_tick_cnt + 8'd1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end

                // A request taken on a boundary edge waits for the next boundary.
                if (r_state == S_RUN && w_accept) begin
                    r_state    <= S_PEND;
                    r_pend_sel <= RATE_SEL;
                end
            end
        end
    end

    assign CFG_ACK  = r_ack;
    assign SLOWCLK  = r_slowclk;
    assign TICK     = r_tick;
    assign TICK_CNT = r_tick_cnt;

endmodule
